// File: rtl/f_divsqrt_pkg.sv
// Shared encodings for the iterative floating-point divide / square-root unit.
package f_divsqrt_pkg;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_SQRT = 1'b1;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PREP  = 2'd1,
        S_ITER  = 2'd2,
        S_ROUND = 2'd3
    } state_e;

    // Canonical quiet NaN for any format: sign 0, exponent all ones, fraction MSB only.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
        v[man_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/f_divsqrt_step.sv
// One restoring iteration: trial-subtract and keep the difference when it does not borrow.
module f_divsqrt_step
    import f_divsqrt_pkg::*;
#(
    parameter int RW = 29
) (
    input  logic [RW-1:0] rem_i,
    input  logic [RW-1:0] sub_i,
    output logic          bit_o,
    output logic [RW-1:0] rem_o
);

    logic [RW:0] diff;

    assign diff  = {1'b0, rem_i} - {1'b0, sub_i};
    assign bit_o = ~diff[RW];
    assign rem_o = bit_o ? diff[RW-1:0] : rem_i;

endmodule

// File: rtl/f_divsqrt.sv
// Iterative IEEE-754 divide / square root: one quotient or root bit per cycle,
// round-to-nearest-even, subnormals flushed to zero.
module f_divsqrt
    import f_divsqrt_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic                   OP,
    input  logic [EXP_W+MAN_W:0]   DATA1,
    input  logic [EXP_W+MAN_W:0]   DATA2,
    input  logic                   KILL,
    output logic                   READY,
    output logic                   VALID,
    output logic [EXP_W+MAN_W:0]   RESULT,
    output logic [4:0]             FLAGS
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int QW  = MAN_W + 3;        // integer bit, fraction, guard, round
    localparam int RW  = MAN_W + 6;
    localparam int RDW = 2 * QW;
    localparam int EW  = EXP_W + 2;
    localparam int CW  = $clog2(MAN_W + 4);

    localparam logic [63:0]          NAN64  = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]         CNAN   = NAN64[W-1:0];
    localparam logic signed [EW-1:0] BIAS_E = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW-1:0] EMAX_E = {2'b00, {EXP_W{1'b1}}};

    state_e                state_q, state_d;
    logic                  op_q, op_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [QW-1:0]         quo_q, quo_d;
    logic [RDW-1:0]        rad_q, rad_d;
    logic [MAN_W:0]        dvs_q, dvs_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic                  sgn_q, sgn_d, spec_q, spec_d, ph_q, ph_d, nx_q, nx_d;
    logic [MAN_W-1:0]      frc_q, frc_d;
    logic [W-1:0]          sres_q, sres_d, res_q, res_d;
    logic [4:0]            sflg_q, sflg_d, flg_q, flg_d;
    logic                  vld_q, vld_d;

    logic                  sa, sb;
    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    logic                  a_zero, a_inf, a_nan, a_snan;
    logic                  b_zero, b_inf, b_nan, b_snan;
    logic [MAN_W:0]        ma, mb;
    logic                  m_lt, sq_odd;
    logic signed [EW-1:0]  ea_x, eb_x, dv_exp, sq_e, sq_ev, sq_exp;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];
    assign ma     = {1'b1, fa};
    assign mb     = {1'b1, fb};
    assign m_lt   = (ma < mb);

    // Dividend is pre-doubled when smaller than the divisor so the quotient lands in [1,2).
    assign ea_x   = $signed({2'b00, ea});
    assign eb_x   = $signed({2'b00, eb});
    assign dv_exp = ea_x - eb_x + BIAS_E - $signed({{(EW-1){1'b0}}, m_lt});
    // Odd unbiased exponents move one factor of two into the radicand.
    assign sq_e   = ea_x - BIAS_E;
    assign sq_odd = sq_e[0];
    assign sq_ev  = sq_e - $signed({{(EW-1){1'b0}}, sq_odd});
    assign sq_exp = (sq_ev >>> 1) + BIAS_E;

    logic [RW-1:0] st_rem, st_sub, st_res;
    logic          st_bit;

    always_comb begin
        if (op_q == OP_DIV) begin
            st_rem = rem_q;
            st_sub = {{(RW-MAN_W-1){1'b0}}, dvs_q};
        end else begin
            st_rem = {rem_q[RW-3:0], rad_q[RDW-1 -: 2]};
            st_sub = {{(RW-QW-2){1'b0}}, quo_q, 2'b01};
        end
    end

    f_divsqrt_step #(.RW(RW)) u_step (
        .rem_i (st_rem),
        .sub_i (st_sub),
        .bit_o (st_bit),
        .rem_o (st_res)
    );

    logic               g_bit, r_bit, s_bit, inc;
    logic [MAN_W+1:0]   rnd_sig;

    assign g_bit   = quo_q[1];
    assign r_bit   = quo_q[0];
    assign s_bit   = (rem_q != '0);
    assign inc     = g_bit && (r_bit || s_bit || quo_q[2]);
    assign rnd_sig = {1'b0, quo_q[QW-1:2]} + (MAN_W+2)'(inc);

    always_comb begin
        state_d = state_q;  op_d   = op_q;   a_d    = a_q;    b_d    = b_q;
        cnt_d   = cnt_q;    rem_d  = rem_q;  quo_d  = quo_q;  rad_d  = rad_q;
        dvs_d   = dvs_q;    exp_d  = exp_q;  sgn_d  = sgn_q;  spec_d = spec_q;
        ph_d    = ph_q;     nx_d   = nx_q;   frc_d  = frc_q;  sres_d = sres_q;
        sflg_d  = sflg_q;   res_d  = res_q;  flg_d  = flg_q;  vld_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !KILL) begin
                    op_d    = OP;
                    a_d     = DATA1;
                    b_d     = DATA2;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                cnt_d  = '0;
                quo_d  = '0;
                ph_d   = 1'b0;
                spec_d = 1'b1;
                sflg_d = '0;
                if (op_q == OP_SQRT) begin
                    sgn_d = sa;
                    if (a_nan) begin
                        sres_d = CNAN;
                        sflg_d[FLG_NV] = a_snan;
                    end else if (a_zero) begin
                        sres_d = {sa, {(W-1){1'b0}}};
                    end else if (sa) begin
                        sres_d = CNAN;
                        sflg_d[FLG_NV] = 1'b1;
                    end else if (a_inf) begin
                        sres_d = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else begin
                        spec_d = 1'b0;
                    end
                    rem_d = '0;
                    rad_d = sq_odd ? {1'b1, fa, 1'b0, {(MAN_W+4){1'b0}}}
                                   : {2'b01, fa, {(MAN_W+4){1'b0}}};
                    exp_d = sq_exp;
                end else begin
                    sgn_d = sa ^ sb;
                    if (a_nan || b_nan) begin
                        sres_d = CNAN;
                        sflg_d[FLG_NV] = a_snan || b_snan;
                    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        sres_d = CNAN;
                        sflg_d[FLG_NV] = 1'b1;
                    end else if (a_inf) begin
                        sres_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (b_zero) begin
                        sres_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        sflg_d[FLG_DZ] = 1'b1;
                    end else if (a_zero || b_inf) begin
                        sres_d = {sa ^ sb, {(W-1){1'b0}}};
                    end else begin
                        spec_d = 1'b0;
                    end
                    rem_d = m_lt ? {{(RW-MAN_W-2){1'b0}}, ma, 1'b0}
                                 : {{(RW-MAN_W-1){1'b0}}, ma};
                    dvs_d = mb;
                    exp_d = dv_exp;
                end
                state_d = spec_d ? S_ROUND : S_ITER;
            end
            S_ITER: begin
                quo_d = {quo_q[QW-2:0], st_bit};
                if (op_q == OP_SQRT) begin
                    rem_d = st_res;
                    rad_d = {rad_q[RDW-3:0], 2'b00};
                end else begin
                    rem_d = {st_res[RW-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(QW-1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                if (spec_q) begin
                    res_d   = sres_q;
                    flg_d   = sflg_q;
                    vld_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (!ph_q) begin
                    // Rounding carry out of the significand bumps the exponent; fraction is then zero.
                    frc_d = rnd_sig[MAN_W-1:0];
                    exp_d = exp_q + $signed({{(EW-1){1'b0}}, rnd_sig[MAN_W+1]});
                    nx_d  = g_bit || r_bit || s_bit;
                    ph_d  = 1'b1;
                end else begin
                    flg_d   = '0;
                    vld_d   = 1'b1;
                    state_d = S_IDLE;
                    if (exp_q >= EMAX_E) begin
                        res_d = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flg_d[FLG_OF] = 1'b1;
                        flg_d[FLG_NX] = 1'b1;
                    end else if (exp_q[EW-1] || exp_q == '0) begin
                        res_d = {sgn_q, {(W-1){1'b0}}};
                        flg_d[FLG_UF] = 1'b1;
                        flg_d[FLG_NX] = 1'b1;
                    end else begin
                        res_d = {sgn_q, exp_q[EXP_W-1:0], frc_q};
                        flg_d[FLG_NX] = nx_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (KILL && state_q != S_IDLE) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            res_d   = res_q;
            flg_d   = flg_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE; op_q  <= 1'b0; a_q    <= '0;   b_q    <= '0;
            cnt_q   <= '0;     rem_q <= '0;   quo_q  <= '0;   rad_q  <= '0;
            dvs_q   <= '0;     exp_q <= '0;   sgn_q  <= 1'b0; spec_q <= 1'b0;
            ph_q    <= 1'b0;   nx_q  <= 1'b0; frc_q  <= '0;   sres_q <= '0;
            sflg_q  <= '0;     res_q <= '0;   flg_q  <= '0;   vld_q  <= 1'b0;
        end else begin
            state_q <= state_d; op_q  <= op_d;  a_q    <= a_d;   b_q    <= b_d;
            cnt_q   <= cnt_d;   rem_q <= rem_d; quo_q  <= quo_d; rad_q  <= rad_d;
            dvs_q   <= dvs_d;   exp_q <= exp_d; sgn_q  <= sgn_d; spec_q <= spec_d;
            ph_q    <= ph_d;    nx_q  <= nx_d;  frc_q  <= frc_d; sres_q <= sres_d;
            sflg_q  <= sflg_d;  res_q <= res_d; flg_q  <= flg_d; vld_q  <= vld_d;
        end
    end

    assign READY  = (state_q == S_IDLE);
    assign VALID  = vld_q;
    assign RESULT = res_q;
    assign FLAGS  = flg_q;

endmodule

// File: tb/tb_f_divsqrt.sv
// Table-driven scoreboard bench for f_divsqrt at single-precision defaults.
module tb_f_divsqrt;

    logic        CLK = 1'b0;
    logic        RESET, START, OP, KILL;
    logic [31:0] DATA1, DATA2;
    logic        READY, VALID;
    logic [31:0] RESULT;
    logic [4:0]  FLAGS;

    f_divsqrt dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
        .DATA1(DATA1), .DATA2(DATA2), .KILL(KILL),
        .READY(READY), .VALID(VALID), .RESULT(RESULT), .FLAGS(FLAGS)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [4:0] flg; int lat; } vec_t;
    typedef struct { logic [31:0] res; logic [4:0] flg; int acc; int lat; } exp_t;

    exp_t sbq[$];
    vec_t vq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   vcount = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (VALID) vcount <= vcount + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b, output int acc);
        chk("ready_before_start", 32'(READY), 32'd1);
        START = 1'b1; OP = op; DATA1 = a; DATA2 = b;
        @(posedge CLK); #1;
        acc = cyc;
        @(negedge CLK);
        START = 1'b0; OP = ~op; DATA1 = $urandom; DATA2 = $urandom;
    endtask

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [4:0] flg, input int lat);
        int acc;
        launch(op, a, b, acc);
        sbq.push_back('{res, flg, acc, lat});
    endtask

    task automatic wait_valid(input string nm);
        exp_t e;
        int   n;
        n = 0;
        while (!VALID && n < 60) begin
            @(negedge CLK);
            n++;
        end
        e = sbq.pop_front();
        total++;
        if (!VALID) begin
            bad++;
            $display("FAIL %s timeout got=no_valid want=valid", nm);
        end else begin
            chk({nm, ".res"}, RESULT, e.res);
            chk({nm, ".flg"}, 32'(FLAGS), 32'(e.flg));
            chk({nm, ".lat"}, 32'(cyc - e.acc), 32'(e.lat));
        end
    endtask

    initial begin
        int v0;
        int acc;

        vq.push_back('{1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 29});
        vq.push_back('{1'b1, 32'h40000000, 32'h00000000, 32'h3FB504F3, 5'h01, 29});
        vq.push_back('{1'b1, 32'h40800000, 32'h00000000, 32'h40000000, 5'h00, 29});
        vq.push_back('{1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 2});
        vq.push_back('{1'b1, 32'hBF800000, 32'h00000000, 32'h7FC00000, 5'h10, 2});
        vq.push_back('{1'b0, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'h05, 29});
        vq.push_back('{1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 5'h03, 29});
        vq.push_back('{1'b0, 32'h00000000, 32'h80000000, 32'h7FC00000, 5'h10, 2});
        vq.push_back('{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'h10, 2});
        vq.push_back('{1'b0, 32'h7F800000, 32'h40000000, 32'h7F800000, 5'h00, 2});
        vq.push_back('{1'b0, 32'hC0000000, 32'h7F800000, 32'h80000000, 5'h00, 2});
        vq.push_back('{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 5'h00, 2});
        vq.push_back('{1'b1, 32'hFF800000, 32'h00000000, 32'h7FC00000, 5'h10, 2});
        vq.push_back('{1'b1, 32'h7F800000, 32'h00000000, 32'h7F800000, 5'h00, 2});
        vq.push_back('{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 2});
        vq.push_back('{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00, 2});
        vq.push_back('{1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 29});
        vq.push_back('{1'b0, 32'h00400000, 32'h3F800000, 32'h00000000, 5'h00, 2});
        vq.push_back('{1'b0, 32'hBF800000, 32'h3F800000, 32'hBF800000, 5'h00, 29});
        vq.push_back('{1'b1, 32'h3E800000, 32'h00000000, 32'h3F000000, 5'h00, 29});
        vq.push_back('{1'b1, 32'h41100000, 32'h00000000, 32'h40400000, 5'h00, 29});
        vq.push_back('{1'b0, 32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'h01, 29});

        RESET = 1'b0; START = 1'b0; KILL = 1'b0; OP = 1'b0; DATA1 = '0; DATA2 = '0;
        #3;
        chk("rst.ready",  32'(READY), 32'd1);
        chk("rst.valid",  32'(VALID), 32'd0);
        chk("rst.result", RESULT, 32'd0);
        chk("rst.flags",  32'(FLAGS), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // Back-to-back: each new request is driven in the VALID cycle.
        for (int i = 0; i < vq.size(); i++) begin
            issue(vq[i].op, vq[i].a, vq[i].b, vq[i].res, vq[i].flg, vq[i].lat);
            wait_valid($sformatf("vec%0d", i));
        end

        // A second START while busy is dropped; the first result stands.
        @(negedge CLK);
        v0 = vcount;
        issue(1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 29);
        repeat (5) @(negedge CLK);
        START = 1'b1; OP = 1'b1; DATA1 = 32'h40800000; DATA2 = 32'h3F800000;
        @(negedge CLK);
        START = 1'b0;
        wait_valid("busy");
        @(negedge CLK);
        chk("busy.pulse", 32'(VALID), 32'd0);
        repeat (3) @(negedge CLK);
        chk("busy.hold", RESULT, 32'h3EAAAAAB);
        repeat (40) @(negedge CLK);
        chk("busy.count", 32'(vcount - v0), 32'd1);

        // Abort at cycle 10, then KILL beating START in IDLE.
        v0 = vcount;
        launch(1'b0, 32'h40C00000, 32'h40000000, acc);
        while (cyc < acc + 10) @(negedge CLK);
        chk("kill.busy", 32'(READY), 32'd0);
        KILL = 1'b1;
        @(posedge CLK); #1;
        chk("kill.ready", 32'(READY), 32'd1);
        @(negedge CLK);
        START = 1'b1; OP = 1'b0; DATA1 = 32'h3F800000; DATA2 = 32'h40400000;
        @(posedge CLK); #1;
        chk("kill.prio", 32'(READY), 32'd1);
        @(negedge CLK);
        START = 1'b0; KILL = 1'b0;
        repeat (40) @(negedge CLK);
        chk("kill.novalid", 32'(vcount - v0), 32'd0);
        chk("kill.hold", RESULT, 32'h3EAAAAAB);

        // Reset in the middle of a divide.
        launch(1'b0, 32'h40C00000, 32'h40000000, acc);
        while (cyc < acc + 15) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("mrst.ready",  32'(READY), 32'd1);
        chk("mrst.valid",  32'(VALID), 32'd0);
        chk("mrst.result", RESULT, 32'd0);
        chk("mrst.flags",  32'(FLAGS), 32'd0);
        v0 = vcount;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (40) @(negedge CLK);
        chk("mrst.novalid", 32'(vcount - v0), 32'd0);
        issue(1'b1, 32'h40000000, 32'h00000000, 32'h3FB504F3, 5'h01, 29);
        wait_valid("mrst.next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/f_divsqrt.md
F_DIVSQRT -- requirements
Module: f_divsqrt

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  in  1  request valid; accepted on a rising edge where START=1 and READY=1.
REQ-006 SHALL have port OP  in  1  0 = DATA1/DATA2, 1 = sqrt(DATA1).
REQ-007 SHALL have port DATA1, DATA2  in  W each  IEEE-754-format operands.
REQ-008 SHALL have port KILL  in  1  synchronous abort.
REQ-009 SHALL have port READY  out  1  high only in IDLE.
REQ-010 SHALL have port VALID  out  1  one-cycle result strobe.
REQ-011 SHALL have port RESULT  out  W  registered result, held until next VALID.
REQ-012 SHALL have port FLAGS  out  5  {NV,DZ,OF,UF,NX}, bit 4 = NV, registered with RESULT.

Function
REQ-013 SHALL implement FSM IDLE -> PREP -> ITER -> ROUND -> IDLE; PREP -> ROUND directly for special operands.
REQ-014 SHALL capture OP/DATA1/DATA2 on accept; later operand changes SHALL have no effect.
REQ-015 SHALL run ITER for exactly MAN_W+3 cycles: radix-2 restoring divide or digit-by-digit sqrt, one quotient/root bit per cycle, producing guard and round bits, with sticky = (remainder != 0).
REQ-016 SHALL assert VALID for exactly one cycle, MAN_W+6 cycles after the accepting edge for normal operands (29 at defaults), 2 cycles for special cases.
REQ-017 SHALL round to nearest, ties to even, only; NX = guard|round|sticky after normalisation.
REQ-018 SHALL flush subnormal inputs to signed zero; results below min normal SHALL become signed zero with UF=1, NX=1.
REQ-019 SHALL saturate exponent overflow to signed infinity with OF=1, NX=1.
REQ-020 SHALL produce canonical NaN (sign 0, exponent all ones, fraction MSB 1, rest 0) for any NaN result; NV=1 if any input is signalling NaN.
REQ-021 Divide: 0/0 and inf/inf -> NaN, NV; finite nonzero/0 -> inf with sign = s1^s2, DZ; inf/x -> inf; x/inf and 0/x -> zero.
REQ-022 Sqrt: -0 -> -0 with no flags; negative nonzero (including -inf) -> NaN, NV; +inf -> +inf.
REQ-023 SHALL ignore START while READY=0, with no queuing.
REQ-024 KILL SHALL return the FSM to IDLE on the next edge with no VALID; KILL has priority over START in the same cycle.
REQ-025 SHALL allow READY=1 in the cycle after VALID; back-to-back requests SHALL be accepted.

Reset
REQ-026 RESET low SHALL immediately force IDLE, READY=1, VALID=0, RESULT=0, FLAGS=0, iteration counter 0.
REQ-027 RESET mid-operation SHALL discard the operation, and no VALID SHALL follow reset release.

Structure
REQ-028 Shared package SHALL hold OP encodings, FLAGS bit positions, canonical-NaN constant and FSM state encodings.
REQ-029 The one-bit iteration step SHALL be sub-module f_divsqrt_step, shared by divide and sqrt.
REQ-030 The iteration counter SHALL be sized clog2(MAN_W+4).

Verification
REQ-031 0x3F800000 / 0x40400000 -> RESULT 0x3EAAAAAB, FLAGS NX only, VALID at cycle 29.
REQ-032 sqrt 0x40000000 -> 0x3FB504F3, NX; sqrt 0x40800000 -> 0x40000000, FLAGS 0.
REQ-033 0x3F800000 / 0x00000000 -> 0x7F800000, DZ, VALID at cycle 2; sqrt 0xBF800000 -> 0x7FC00000, NV.
REQ-034 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, OF|NX; 0x00800000 / 0x40000000 -> 0x00000000, UF|NX.
REQ-035 START during ITER with different operands -> ignored, first result unchanged; KILL at cycle 10 -> no VALID, READY=1 at cycle 11.
REQ-036 RESET low at cycle 15 of a divide -> outputs zero immediately, no VALID after release, next request correct.
